// File: rtl/windowed_pair_detector.sv
// Sliding-window popcount detector: sums the ones of the last WINDOW accepted
// samples and flags when that sum reaches THRESH (or stays below it, in inverted mode).
module windowed_pair_detector #(
  parameter int NBITS  = 3,
  parameter int WINDOW = 4,
  parameter int THRESH = 2,
  localparam int CW    = $clog2(NBITS*WINDOW+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  input  logic [NBITS-1:0] in,
  input  logic             clear,
  input  logic             mode,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             out
);

  localparam int PW = $clog2(NBITS+1);
  localparam int FW = $clog2(WINDOW+1);
  localparam int XW = CW + 1;

  logic [PW-1:0] pc;
  logic [PW-1:0] slot_q [WINDOW];
  logic [FW-1:0] fill_q;
  logic [CW-1:0] count_q;
  logic [XW-1:0] count_d;
  logic          accept;

  assign accept = in_val & ~clear;

  always_comb begin
    pc = '0;
    for (int i = 0; i < NBITS; i++) begin
      pc = pc + PW'(in[i]);
    end
  end

  assign full = (fill_q == FW'(WINDOW));

  // One spare bit so the add-then-subtract never wraps before the evicted slot is removed.
  always_comb begin
    count_d = XW'(count_q) + XW'(pc) - (full ? XW'(slot_q[WINDOW-1]) : XW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      fill_q  <= '0;
    end else if (clear) begin
      count_q <= '0;
      fill_q  <= '0;
    end else if (accept) begin
      count_q <= count_d[CW-1:0];
      if (!full) begin
        fill_q <= fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
    end else if (clear) begin
      slot_q[0] <= '0;
    end else if (accept) begin
      slot_q[0] <= pc;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < WINDOW; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_q[gi] <= '0;
        end else if (clear) begin
          slot_q[gi] <= '0;
        end else if (accept) begin
          slot_q[gi] <= slot_q[gi-1];
        end
      end
    end
  endgenerate

  assert property (@(posedge clk) disable iff (!rst_n) !count_d[CW]);

  assign count = count_q;
  assign out   = mode ? (XW'(count_q) < XW'(THRESH)) : (XW'(count_q) >= XW'(THRESH));

endmodule

// File: doc/windowed_pair_detector.md
Name: windowed_pair_detector

Overview:
- Sequential, parametrised successor to the team's combinational 3-input pair/triple detector.
- Each accepted sample is an NBITS-wide vector. The block takes its population count and keeps a running total over the last WINDOW accepted samples.
- It flags when the total reaches THRESH, or, in inverted mode, when it has not reached THRESH.
- With WINDOW=1, THRESH=2, mode=1 it is a registered 3-input "no pair present" detector. Used for lab datapath status and event-density monitoring.

Parameters:
- NBITS, 3: bits per input sample; must be >= 1.
- WINDOW, 4: number of accepted samples in the sliding window; must be >= 1.
- THRESH, 2: comparison threshold; legal range 1..NBITS*WINDOW.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_val  input  1  sample qualifier; in is accepted on a rising edge when in_val=1.
- in  input  NBITS  sample vector.
- clear  input  1  synchronous window flush.
- mode  input  1  0 = assert when count >= THRESH; 1 = assert when count < THRESH.
- count  output  CW  running sum of ones over the window; CW = $clog2(NBITS*WINDOW+1).
- full  output  1  window holds WINDOW samples.
- out  output  1  detector result.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). Assertion clears state immediately, independent of clk; deassertion is synchronous to clk by the surrounding system.
- Reset values:
  - window slots = 0, fill = 0, count = 0, full = 0.
  - out = 0 when mode=0; out = 1 when mode=1.
- State:
  - WINDOW-entry shift register of per-sample popcounts, each clog2(NBITS+1) bits.
  - Fill counter 0..WINDOW, saturating.
  - count register.
- Accept (in_val=1, clear=0) at edge:
  - pc = popcount(in).
  - Slot 0 <= pc; slot k <= slot k-1.
  - count <= count + pc - (full ? slot WINDOW-1 : 0).
  - fill <= min(fill+1, WINDOW).
- Idle (in_val=0, clear=0): all state holds.
- clear=1 at edge:
  - slots, fill and count <= 0.
  - If in_val is also 1, clear wins and the sample is discarded.
- Latency:
  - count and full reflect a sample one cycle after the accepting edge.
  - out is a combinational function of the registered count and the live mode: out = mode ? (count < THRESH) : (count >= THRESH).
  - A mode change affects out in the same cycle, with no state change.
- Partial window: before full=1, count covers only the accepted samples and out is evaluated on that partial count. No suppression.
- full = (fill == WINDOW). Once full, each accept evicts the oldest slot and full stays 1 until clear or reset.
- Arithmetic:
  - count never exceeds NBITS*WINDOW and never underflows; the subtract uses the evicted slot exactly.
  - Compute at CW+1 bits internally; no wrap permitted.
- WINDOW=1: the window degenerates to the last sample; count = popcount of the most recent accepted in.
- Reset mid-operation: all state zeroed asynchronously. The first accept after release starts from an empty window.

Test Plan:
- Reset, then release with mode=0: count=0, full=0, out=0. Set mode=1 -> out=1 the same cycle.
- Defaults, mode=0: accept 3'b001, 3'b010, 3'b000, 3'b000 -> count 1,2,2,2 on successive cycles; out rises the cycle after the second accept; full=1 after the fourth.
- Window slide, defaults, mode=0: accept 3'b111 then four 3'b000 -> count 3,3,3,3,0; out drops after the fifth accept.
- Idle and clear: gap in_val=0 for 5 cycles -> count held. Then clear=1 together with in_val=1, in=3'b111 -> count=0, full=0, sample discarded.
- WINDOW=1, THRESH=2, mode=1: sweep all 8 values of in -> out=1 exactly for 000, 001, 010, 100, one cycle after each accept.
- Async reset mid-stream with count=5: drop rst_n between edges -> count=0 and full=0 immediately. The next accept of 3'b011 -> count=2.
